serial_adder: RTL and testbench

Bit-serial N-bit adder built around the existing 1-bit `full_adder`, which it instantiates. It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It feeds one bit pair per clock, LSB first, into the `full_adder` and keeps the ripple carry in a flop. The assembled sum and carry-out are presented on an output valid/ready handshake. It sits directly upstream of the `full_adder` cell, sequencing its inputs and consuming its outputs.

---
 rtl/serial_adder_pkg.sv | 10 +
 rtl/serial_adder_if.sv | 28 ++
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 84 ++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/serial_adder_if.sv
// Operand-in / result-out handshake bundle for serial_adder.
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout
   );

   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout
   );

endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell; the only arithmetic in the serial adder datapath.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   assign sum       = a ^ b ^ carry_in;
   assign carry_out = (a & b) | (carry_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per clock, LSB first,
// through a single full_adder and assembles the sum in a right-shifting register.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic           clk,
   input logic           rst,
   serial_adder_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] s_sh;
   logic [WIDTH-1:0] s_next;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_sum;
   logic             fa_cout;

   full_adder u_fa (
      .a         (a_sh[0]),
      .b         (b_sh[0]),
      .carry_in  (carry),
      .sum       (fa_sum),
      .carry_out (fa_cout)
   );

   // Written as shift-then-insert so WIDTH = 1 needs no special slice.
   always_comb begin
      s_next            = s_sh >> 1;
      s_next[WIDTH-1]   = fa_sum;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the datapath registers are reset too, because sum/cout are
         // visible outputs and must read 0 after reset.
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         s_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sh  <= bus.a;
                  b_sh  <= bus.b;
                  s_sh  <= '0;
                  carry <= bus.cin;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> 1;
               b_sh  <= b_sh >> 1;
               s_sh  <= s_next;
               carry <= fa_cout;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) state <= DONE;
            end
            DONE: begin
               if (bus.out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.sum       = s_sh;
   assign bus.cout      = carry;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH 8, 4 and 1 against an
// arithmetic reference (a + b + cin).
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_adder_if #(.WIDTH(8)) if8 ();
   serial_adder_if #(.WIDTH(4)) if4 ();
   serial_adder_if #(.WIDTH(1)) if1 ();

   serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
   serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
   serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // One WIDTH=8 transaction with out_ready held high; returns the result,
   // edges from accept to out_valid, and the cycle index of the accept edge.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output logic [7:0] s, output logic c, output int lat, output int acc);
      @(negedge clk);
      total_cnt++;
      if (if8.in_ready !== 1'b1) $display("FAIL op8_in_ready: got %b expected 1", if8.in_ready);
      else pass_cnt++;
      if8.a = a; if8.b = b; if8.cin = cin; if8.in_valid = 1'b1; if8.out_ready = 1'b1;
      @(negedge clk);
      acc = cyc;
      if8.in_valid = 1'b0;
      lat = 0;
      while (if8.out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      s = if8.sum;
      c = if8.cout;
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                      output logic [3:0] s, output logic c, output int lat, output int acc);
      @(negedge clk);
      if4.a = a; if4.b = b; if4.cin = cin; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
      @(negedge clk);
      acc = cyc;
      if4.in_valid = 1'b0;
      lat = 0;
      while (if4.out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      s = if4.sum;
      c = if4.cout;
   endtask

   task automatic check8(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic cin);
      logic [7:0] s;
      logic       c;
      int         lat, acc;
      logic [8:0] exp;
      exp = 9'(a) + 9'(b) + 9'(cin);
      op8(a, b, cin, s, c, lat, acc);
      total_cnt++;
      if ({c, s} !== exp || lat != 8)
         $display("FAIL %s: a=%h b=%h cin=%b got cout=%b sum=%h lat=%0d expected cout=%b sum=%h lat=8",
                  name, a, b, cin, c, s, lat, exp[8], exp[7:0]);
      else pass_cnt++;
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout} !== {1'b1, 1'b0, 8'h00, 1'b0} ||
          {if4.in_ready, if4.out_valid, if4.sum, if4.cout} !== {1'b1, 1'b0, 4'h0, 1'b0} ||
          {if1.in_ready, if1.out_valid, if1.sum, if1.cout} !== {1'b1, 1'b0, 1'b0, 1'b0})
         $display("FAIL reset_state: got w8 rdy=%b vld=%b sum=%h cout=%b expected rdy=1 vld=0 sum=0 cout=0",
                  if8.in_ready, if8.out_valid, if8.sum, if8.cout);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_zero_latency;
      check8("zero_operands", 8'h00, 8'h00, 1'b0);
   endtask

   task automatic test_carry;
      check8("carry_ff_01", 8'hFF, 8'h01, 1'b0);
      check8("carry_a5_5a_cin", 8'hA5, 8'h5A, 1'b1);
   endtask

   task automatic test_backpressure;
      int waited;
      @(negedge clk);
      if8.a = 8'h3C; if8.b = 8'h0F; if8.cin = 1'b0; if8.in_valid = 1'b1; if8.out_ready = 1'b0;
      @(negedge clk);
      if8.in_valid = 1'b0;
      waited = 0;
      while (if8.out_valid !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      total_cnt++;
      if (waited != 8) $display("FAIL bp_latency: got %0d expected 8", waited);
      else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         total_cnt++;
         if ({if8.out_valid, if8.in_ready, if8.sum, if8.cout} !== {1'b1, 1'b0, 8'h4B, 1'b0})
            $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b sum=%h cout=%b expected vld=1 rdy=0 sum=4b cout=0",
                     i, if8.out_valid, if8.in_ready, if8.sum, if8.cout);
         else pass_cnt++;
         if (i == 1) begin
            if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1; if8.in_valid = 1'b1;
         end else begin
            if8.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      if8.in_valid = 1'b0;
      if8.out_ready = 1'b1;
      @(negedge clk);
      total_cnt++;
      if ({if8.in_ready, if8.out_valid} !== 2'b10)
         $display("FAIL bp_release: got rdy=%b vld=%b expected rdy=1 vld=0", if8.in_ready, if8.out_valid);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({if8.in_ready, if8.out_valid} !== 2'b10)
         $display("FAIL bp_pulse_ignored: got rdy=%b vld=%b expected rdy=1 vld=0", if8.in_ready, if8.out_valid);
      else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      bit seen_valid;
      @(negedge clk);
      if8.a = 8'h77; if8.b = 8'h11; if8.cin = 1'b1; if8.in_valid = 1'b1;
      @(negedge clk);
      if8.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total_cnt++;
      if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout} !== {1'b1, 1'b0, 8'h00, 1'b0})
         $display("FAIL rst_mid_state: got rdy=%b vld=%b sum=%h cout=%b expected rdy=1 vld=0 sum=0 cout=0",
                  if8.in_ready, if8.out_valid, if8.sum, if8.cout);
      else pass_cnt++;
      seen_valid = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (if8.out_valid !== 1'b0) seen_valid = 1'b1;
      end
      total_cnt++;
      if (seen_valid) $display("FAIL rst_mid_no_valid: got out_valid=1 expected 0");
      else pass_cnt++;
      check8("after_reset", 8'h10, 8'h20, 1'b1);
   endtask

   task automatic test_random;
      for (int i = 0; i < 25; i++) begin
         check8("random", 8'($urandom), 8'($urandom), 1'($urandom));
      end
   endtask

   task automatic test_exhaustive_w4;
      logic [3:0] s;
      logic       c;
      int         lat, acc, prev_acc;
      int         exp;
      prev_acc = -1;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            for (int ci = 0; ci < 2; ci++) begin
               op4(4'(a), 4'(b), 1'(ci), s, c, lat, acc);
               exp = a + b + ci;
               total_cnt++;
               if ({c, s} !== 5'(exp) || lat != 4)
                  $display("FAIL w4_sum: a=%0d b=%0d cin=%0d got %0d lat=%0d expected %0d lat=4",
                           a, b, ci, {c, s}, lat, exp);
               else pass_cnt++;
               if (prev_acc >= 0) begin
                  total_cnt++;
                  if (acc - prev_acc != 6)
                     $display("FAIL w4_ii: got %0d expected 6", acc - prev_acc);
                  else pass_cnt++;
               end
               prev_acc = acc;
            end
         end
      end
   endtask

   task automatic test_width1;
      int lat;
      @(negedge clk);
      if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
      @(negedge clk);
      if1.in_valid = 1'b0;
      lat = 0;
      while (if1.out_valid !== 1'b1 && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      total_cnt++;
      if ({if1.cout, if1.sum} !== 2'b11 || lat != 1)
         $display("FAIL w1_sum: got cout=%b sum=%b lat=%0d expected cout=1 sum=1 lat=1",
                  if1.cout, if1.sum, lat);
      else pass_cnt++;
   endtask

   initial begin
      if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b1;
      if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b1;
      if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0; if1.out_ready = 1'b1;
      test_reset;
      test_zero_latency;
      test_carry;
      test_backpressure;
      test_reset_mid;
      test_random;
      test_exhaustive_w4;
      test_width1;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
